// File: rtl/seven_seg_scan_ctrl_if.sv
// CPU register bus for the seven-segment scan controller.
// The CPU side drives strobes and write data; the controller returns registered read data.
interface seven_seg_scan_ctrl_if;
   logic        we;
   logic        re;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output we, re, addr, wdata, input rdata);
   modport slave  (input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan controller: shadow DATA/CTRL registers, digit scan, blink clock and
// half-word paging. CPU writes reach the display only at a scan-frame boundary.
module seven_seg_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int FLASH_FRAMES = 64,
   parameter int PAGE_FRAMES  = 512
) (
   input  logic                clk,
   input  logic                rst_n,
   seven_seg_scan_ctrl_if.slave bus,
   output logic [31:0]         disp_num_o,
   output logic                graph_o,
   output logic                high_degree_o,
   output logic [1:0]          scanning_o,
   output logic [3:0]          pointing_o,
   output logic [3:0]          blinking_o,
   output logic                flash_clk_o
);

   localparam int SW = (SCAN_DIV     > 1) ? $clog2(SCAN_DIV)     : 1;
   localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int PW = (PAGE_FRAMES  > 1) ? $clog2(PAGE_FRAMES)  : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
   localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_FRAMES - 1);

   logic [SW-1:0] scan_cnt_q,  scan_cnt_d;
   logic [1:0]    scan_idx_q,  scan_idx_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic          flash_q,     flash_d;
   logic [PW-1:0] page_cnt_q,  page_cnt_d;
   logic          hd_q,        hd_d;
   logic          man_hd_q,    man_hd_d;
   logic [31:0]   data_sh_q,   data_sh_d;
   logic [11:0]   ctrl_sh_q,   ctrl_sh_d;
   logic          pend_q,      pend_d;
   logic [31:0]   disp_q,      disp_d;
   logic          graph_q,     graph_d;
   logic [3:0]    point_q,     point_d;
   logic [3:0]    blink_q,     blink_d;
   logic [31:0]   rdata_q,     rdata_d;

   logic scan_tc, frame_end, commit, auto_page;

   always_comb begin
      scan_cnt_d  = scan_cnt_q;
      scan_idx_d  = scan_idx_q;
      frame_cnt_d = frame_cnt_q;
      flash_cnt_d = flash_cnt_q;
      flash_d     = flash_q;
      page_cnt_d  = page_cnt_q;
      hd_d        = hd_q;
      man_hd_d    = man_hd_q;
      data_sh_d   = data_sh_q;
      ctrl_sh_d   = ctrl_sh_q;
      pend_d      = pend_q;
      disp_d      = disp_q;
      graph_d     = graph_q;
      point_d     = point_q;
      blink_d     = blink_q;
      rdata_d     = rdata_q;

      scan_tc   = (scan_cnt_q == SCAN_LAST);
      frame_end = scan_tc && (scan_idx_q == 2'd3);
      commit    = frame_end && pend_q;
      auto_page = ctrl_sh_q[2];

      scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
      if (scan_tc) scan_idx_d = scan_idx_q + 2'd1;

      if (frame_end) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
         end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
         end
      end

      // Manual mode tracks the committed page bit so it switches in step with the other outputs
      if (auto_page) begin
         if (frame_end) begin
            if (page_cnt_q == PAGE_LAST) begin
               page_cnt_d = '0;
               hd_d       = ~hd_q;
            end else begin
               page_cnt_d = page_cnt_q + 1'b1;
            end
         end
      end else begin
         page_cnt_d = '0;
         hd_d       = commit ? ctrl_sh_q[1] : man_hd_q;
      end

      // Commit reads the registered shadow, so a same-cycle write lands one frame later
      if (commit) begin
         disp_d   = data_sh_q;
         graph_d  = ctrl_sh_q[0];
         man_hd_d = ctrl_sh_q[1];
         point_d  = ctrl_sh_q[7:4];
         blink_d  = ctrl_sh_q[11:8];
         pend_d   = 1'b0;
      end

      if (bus.we) begin
         case (bus.addr)
            2'd0: begin
               data_sh_d = bus.wdata;
               pend_d    = 1'b1;
            end
            2'd1: begin
               ctrl_sh_d = bus.wdata[11:0];
               pend_d    = 1'b1;
            end
            default: ;
         endcase
      end

      if (bus.re) begin
         case (bus.addr)
            2'd0:    rdata_d = data_sh_q;
            2'd1:    rdata_d = {20'b0, ctrl_sh_q};
            2'd2:    rdata_d = {frame_cnt_q, 15'b0, pend_q};
            default: rdata_d = 32'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         scan_idx_q  <= '0;
         frame_cnt_q <= '0;
         flash_cnt_q <= '0;
         flash_q     <= 1'b0;
         page_cnt_q  <= '0;
         hd_q        <= 1'b0;
         man_hd_q    <= 1'b0;
         data_sh_q   <= '0;
         ctrl_sh_q   <= '0;
         pend_q      <= 1'b0;
         disp_q      <= '0;
         graph_q     <= 1'b0;
         point_q     <= '0;
         blink_q     <= '0;
         rdata_q     <= '0;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         scan_idx_q  <= scan_idx_d;
         frame_cnt_q <= frame_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         flash_q     <= flash_d;
         page_cnt_q  <= page_cnt_d;
         hd_q        <= hd_d;
         man_hd_q    <= man_hd_d;
         data_sh_q   <= data_sh_d;
         ctrl_sh_q   <= ctrl_sh_d;
         pend_q      <= pend_d;
         disp_q      <= disp_d;
         graph_q     <= graph_d;
         point_q     <= point_d;
         blink_q     <= blink_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.rdata     = rdata_q;
   assign disp_num_o    = disp_q;
   assign graph_o       = graph_q;
   assign high_degree_o = hd_q;
   assign scanning_o    = scan_idx_q;
   assign pointing_o    = point_q;
   assign blinking_o    = blink_q;
   assign flash_clk_o   = flash_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SCAN_DIV=4, FLASH_FRAMES=2, PAGE_FRAMES=3.
// Edge n counts rising edges since reset release; one frame is 16 edges.
module tb_seven_seg_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] disp_num;
   logic        graph, high_degree, flash_clk;
   logic [1:0]  scanning;
   logic [3:0]  pointing, blinking;

   int n = 0;
   int total = 0;
   int passed = 0;

   seven_seg_scan_ctrl_if bus_if ();

   seven_seg_scan_ctrl #(.SCAN_DIV(4), .FLASH_FRAMES(2), .PAGE_FRAMES(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus_if),
      .disp_num_o    (disp_num),
      .graph_o       (graph),
      .high_degree_o (high_degree),
      .scanning_o    (scanning),
      .pointing_o    (pointing),
      .blinking_o    (blinking),
      .flash_clk_o   (flash_clk)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      int          cyc;
      bit          we;
      bit          re;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [1:0]  scan;
      bit          flash;
      logic [31:0] disp;
      logic [8:0]  gpb;
      bit          hd;
      bit          chk_rd;
      logic [31:0] rd;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input int cyc, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic idle_bus();
      bus_if.we = 1'b0; bus_if.re = 1'b0; bus_if.addr = 2'd0; bus_if.wdata = 32'd0;
   endtask

   task automatic do_reset();
      idle_bus();
      rst_n = 1'b0;
      #1;
      chk("reset_outputs", 0,
          {disp_num, graph, high_degree, scanning, pointing, blinking, flash_clk, bus_if.rdata}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
   endtask

   task automatic bus_op(input bit we, input bit re, input logic [1:0] addr, input logic [31:0] wd);
      bus_if.we = we; bus_if.re = re; bus_if.addr = addr; bus_if.wdata = wd;
      tick();
      idle_bus();
   endtask

   initial begin
      logic [31:0] disp_acc;
      idle_bus();

      // rst, cyc, we, re, addr, wdata, scan, flash, disp, gpb, hd, chk_rd, rd
      // idle frames
      vq.push_back('{1,   1, 0,0,2'd0,32'h0,        2'd0,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,   4, 0,0,2'd0,32'h0,        2'd1,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,   8, 0,0,2'd0,32'h0,        2'd2,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  12, 0,0,2'd0,32'h0,        2'd3,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  16, 0,0,2'd0,32'h0,        2'd0,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  31, 0,0,2'd0,32'h0,        2'd3,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  32, 0,0,2'd0,32'h0,        2'd0,1,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  40, 0,1,2'd2,32'h0,        2'd2,1,32'h0,       9'h000,0,1,32'h0002_0000});
      // DATA commit, CTRL commit, manual then auto paging
      vq.push_back('{1,   5, 1,0,2'd0,32'h12345678, 2'd1,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,   6, 0,1,2'd2,32'h0,        2'd1,0,32'h0,       9'h000,0,1,32'h0000_0001});
      vq.push_back('{0,   7, 0,1,2'd0,32'h0,        2'd1,0,32'h0,       9'h000,0,1,32'h12345678});
      vq.push_back('{0,  15, 0,0,2'd0,32'h0,        2'd3,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  16, 0,0,2'd0,32'h0,        2'd0,0,32'h12345678,9'h000,0,0,32'h0});
      vq.push_back('{0,  17, 0,1,2'd2,32'h0,        2'd0,0,32'h12345678,9'h000,0,1,32'h0001_0000});
      vq.push_back('{0,  20, 1,0,2'd1,32'hFFFF0A53, 2'd1,0,32'h12345678,9'h000,0,0,32'h0});
      vq.push_back('{0,  21, 0,1,2'd1,32'h0,        2'd1,0,32'h12345678,9'h000,0,1,32'h0000_0A53});
      vq.push_back('{0,  31, 0,0,2'd0,32'h0,        2'd3,0,32'h12345678,9'h000,0,0,32'h0});
      vq.push_back('{0,  32, 0,0,2'd0,32'h0,        2'd0,1,32'h12345678,9'h15A,1,0,32'h0});
      vq.push_back('{0, 112, 0,0,2'd0,32'h0,        2'd0,1,32'h12345678,9'h15A,1,0,32'h0});
      vq.push_back('{0, 113, 1,0,2'd1,32'h00000A57, 2'd0,1,32'h12345678,9'h15A,1,0,32'h0});
      vq.push_back('{0, 128, 0,0,2'd0,32'h0,        2'd0,0,32'h12345678,9'h15A,1,0,32'h0});
      vq.push_back('{0, 129, 0,1,2'd1,32'h0,        2'd0,0,32'h12345678,9'h15A,1,1,32'h0000_0A57});
      vq.push_back('{0, 159, 0,0,2'd0,32'h0,        2'd3,0,32'h12345678,9'h15A,1,0,32'h0});
      vq.push_back('{0, 160, 0,0,2'd0,32'h0,        2'd0,1,32'h12345678,9'h15A,0,0,32'h0});
      vq.push_back('{0, 207, 0,0,2'd0,32'h0,        2'd3,0,32'h12345678,9'h15A,0,0,32'h0});
      vq.push_back('{0, 208, 0,0,2'd0,32'h0,        2'd0,0,32'h12345678,9'h15A,1,0,32'h0});
      // write landing exactly on frame_end, read/write collisions, ignored addresses
      vq.push_back('{1,   3, 1,0,2'd0,32'h11111111, 2'd0,0,32'h0,       9'h000,0,0,32'h0});
      vq.push_back('{0,  16, 1,0,2'd0,32'hCAFEBABE, 2'd0,0,32'h11111111,9'h000,0,0,32'h0});
      vq.push_back('{0,  17, 0,1,2'd2,32'h0,        2'd0,0,32'h11111111,9'h000,0,1,32'h0001_0001});
      vq.push_back('{0,  31, 0,0,2'd0,32'h0,        2'd3,0,32'h11111111,9'h000,0,0,32'h0});
      vq.push_back('{0,  32, 0,0,2'd0,32'h0,        2'd0,1,32'hCAFEBABE,9'h000,0,0,32'h0});
      vq.push_back('{0,  33, 0,1,2'd2,32'h0,        2'd0,1,32'hCAFEBABE,9'h000,0,1,32'h0002_0000});
      vq.push_back('{0,  34, 1,1,2'd0,32'h5555AAAA, 2'd0,1,32'hCAFEBABE,9'h000,0,1,32'hCAFEBABE});
      vq.push_back('{0,  35, 0,1,2'd0,32'h0,        2'd0,1,32'hCAFEBABE,9'h000,0,1,32'h5555AAAA});
      vq.push_back('{0,  36, 0,1,2'd3,32'h0,        2'd1,1,32'hCAFEBABE,9'h000,0,1,32'h0});
      vq.push_back('{0,  37, 1,0,2'd2,32'hFFFFFFFF, 2'd1,1,32'hCAFEBABE,9'h000,0,0,32'h0});
      vq.push_back('{0,  38, 0,1,2'd2,32'h0,        2'd1,1,32'hCAFEBABE,9'h000,0,1,32'h0002_0001});
      vq.push_back('{0,  39, 0,0,2'd0,32'h0,        2'd1,1,32'hCAFEBABE,9'h000,0,1,32'h0002_0001});

      foreach (vq[i]) begin
         if (vq[i].rst) do_reset();
         while (n < vq[i].cyc - 1) tick();
         bus_op(vq[i].we, vq[i].re, vq[i].addr, vq[i].wdata);
         chk("scanning",    n, 80'(scanning),    80'(vq[i].scan));
         chk("flash_clk",   n, 80'(flash_clk),   80'(vq[i].flash));
         chk("disp_num",    n, 80'(disp_num),    80'(vq[i].disp));
         chk("graph_pt_bl", n, 80'({graph, pointing, blinking}), 80'(vq[i].gpb));
         chk("high_degree", n, 80'(high_degree), 80'(vq[i].hd));
         if (vq[i].chk_rd) chk("rdata", n, 80'(bus_if.rdata), 80'(vq[i].rd));
      end

      // Reset pulse mid-frame with two staged writes pending
      do_reset();
      tick();
      bus_op(1'b1, 1'b0, 2'd0, 32'hA5A5A5A5);
      repeat (3) tick();
      bus_op(1'b1, 1'b0, 2'd0, 32'h0F0F0F0F);
      repeat (3) tick();
      chk("pre_pulse_scanning", n, 80'(scanning), 80'(2'd2));
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", n,
          {disp_num, graph, high_degree, scanning, pointing, blinking, flash_clk, bus_if.rdata}, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      bus_op(1'b0, 1'b1, 2'd2, 32'h0);
      chk("status_after_pulse", n, 80'(bus_if.rdata), 80'(32'h0));
      disp_acc = '0;
      while (n < 33) begin
         tick();
         disp_acc |= disp_num;
         if (n == 4) chk("scan_restart", n, 80'(scanning), 80'(2'd1));
      end
      chk("disp_held_zero", n, 80'(disp_acc), 80'(32'h0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
